// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU operation scheduler.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: SEL_W opcode width, W_DEFAULT operand width, res_entry_t result
// FIFO entry {id, y}, tag_t tracker tag {valid, id}.
package alu_sched_pkg;

  localparam int SEL_W     = 3;
  localparam int W_DEFAULT = 16;

  // One returned result: which requester issued it and the W+1 bit ALU output.
  typedef struct packed {
    logic                 id;
    logic [W_DEFAULT:0]   y;
  } res_entry_t;

  // One slot of the in-flight tracker.
  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage

// File: rtl/alu_sched_res_fifo.sv
// First-word-fall-through result FIFO holding res_entry_t entries.
// Latency: a push is visible at the head one edge later; pop takes effect at the edge.
// Backpressure: none internally; the caller guarantees no push while full.
// Ports: clk, rst_n (async active-low), push/push_dat, pop, head (valid when
// !empty), count (registered occupancy), full, empty.
module alu_sched_res_fifo
  import alu_sched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  res_entry_t                   push_dat,
  input  logic                         pop,
  output res_entry_t                   head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  // A 1-deep FIFO still needs a 1-bit pointer to index its single slot.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  res_entry_t     mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count == '0);
  assign full  = (count == ($clog2(DEPTH+1))'(DEPTH));
  assign head  = mem[rd_ptr];

  // Storage carries no reset; the top masks the head while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one registered ALU between two requesters; results return tagged via a FWFT FIFO.
// Latency: handshake at edge k -> res_valid after edge k+ALU_LAT+1 (2 cycles by default).
// Backpressure: issue stops once fifo_count + inflight reaches RES_DEPTH; pops free credit one edge later.
// Ports: r0_*/r1_* requester valid/ready/operands, alu_a/alu_b/alu_sel/alu_y to the ALU,
// res_valid/res_ready/res_id/res_y result stream, busy.
// Build option: ALU_SCHED_STRICT_PRIO_EN makes requester 0 win every tie (no round-robin state).
// W must match alu_sched_pkg::W_DEFAULT because res_entry_t is sized from it.
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int W         = W_DEFAULT,
  parameter int ALU_LAT   = 1,
  parameter int RES_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [W-1:0]     r0_a,
  input  logic [W-1:0]     r0_b,
  input  logic [SEL_W-1:0] r0_sel,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [W-1:0]     r1_a,
  input  logic [W-1:0]     r1_b,
  input  logic [SEL_W-1:0] r1_sel,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [W:0]       alu_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [W:0]       res_y,
  output logic             busy
);

  localparam int CNT_W = $clog2(RES_DEPTH + 1);

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  res_entry_t       fifo_head;
  res_entry_t       fifo_push_dat;
  logic             fifo_push;
  logic             fifo_pop;

  // Stage i holds the tag of the op whose ALU result is valid i edges later;
  // stage ALU_LAT lines up with alu_y.
  tag_t             trk [ALU_LAT+1];
  int               inflight;
  logic             credit_ok;

  logic             gnt0;
  logic             gnt1;
  logic             hs;
  logic             hs_id;

  always_comb begin
    inflight = 0;
    for (int i = 0; i <= ALU_LAT; i++) inflight += int'(trk[i].valid);
  end

  // Registered counts only, so res_ready never reaches rN_ready combinationally.
  assign credit_ok = (int'(fifo_count) + inflight) < RES_DEPTH;

`ifdef ALU_SCHED_STRICT_PRIO_EN
  assign gnt0 = r0_valid;
  assign gnt1 = r1_valid & ~r0_valid;
`else
  // On a tie, the requester that did not win last gets it.
  logic last_grant;
  assign gnt0 = r0_valid & (~r1_valid | last_grant);
  assign gnt1 = r1_valid & (~r0_valid | ~last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  last_grant <= 1'b1;
    else if (hs) last_grant <= hs_id;
  end
`endif

  // rst_n in the product keeps ready low during an asynchronous reset.
  assign r0_ready = credit_ok & gnt0 & rst_n;
  assign r1_ready = credit_ok & gnt1 & rst_n;
  assign hs       = r0_ready | r1_ready;
  assign hs_id    = r1_ready;

  // Operand registers hold the last issued op when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
    end else if (hs) begin
      alu_a   <= hs_id ? r1_a   : r0_a;
      alu_b   <= hs_id ? r1_b   : r0_b;
      alu_sel <= hs_id ? r1_sel : r0_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= ALU_LAT; i++) trk[i] <= '0;
    end else begin
      trk[0] <= '{valid: hs, id: hs_id};
      for (int i = 1; i <= ALU_LAT; i++) trk[i] <= trk[i-1];
    end
  end

  // An op leaves the tracker on the same edge it enters the FIFO, so the
  // credit sum stays constant across capture.
  assign fifo_push     = trk[ALU_LAT].valid;
  assign fifo_push_dat = '{id: trk[ALU_LAT].id, y: alu_y};
  assign fifo_pop      = res_valid & res_ready;

  alu_sched_res_fifo #(
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_dat (fifo_push_dat),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // The credit check makes a push into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(fifo_push && fifo_full));
  end

  assign res_valid = ~fifo_empty;
  assign res_id    = res_valid ? fifo_head.id : 1'b0;
  assign res_y     = res_valid ? fifo_head.y  : '0;
  assign busy      = (inflight != 0) | (fifo_count != '0);

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed bench for alu_op_scheduler with a registered one-cycle ALU model.
// Latency: n/a.
// Backpressure: driven by the bench through res_ready.
module tb_alu_op_scheduler;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         r0_valid, r0_ready, r1_valid, r1_ready;
  logic [W-1:0] r0_a, r0_b, r1_a, r1_b;
  logic [2:0]   r0_sel, r1_sel;
  logic [W-1:0] alu_a, alu_b;
  logic [2:0]   alu_sel;
  logic [W:0]   alu_y;
  logic         res_valid, res_ready, res_id;
  logic [W:0]   res_y;
  logic         busy;

  alu_op_scheduler #(.W(W), .ALU_LAT(1), .RES_DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .r0_valid  (r0_valid),
    .r0_ready  (r0_ready),
    .r0_a      (r0_a),
    .r0_b      (r0_b),
    .r0_sel    (r0_sel),
    .r1_valid  (r1_valid),
    .r1_ready  (r1_ready),
    .r1_a      (r1_a),
    .r1_b      (r1_b),
    .r1_sel    (r1_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_y     (alu_y),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_y     (res_y),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ALU, one edge from operand capture to y.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) alu_y <= '0;
    else begin
      case (alu_sel)
        3'd0: alu_y <= {1'b0, alu_a} + {1'b0, alu_b};
        3'd1: alu_y <= {1'b0, alu_a} - {1'b0, alu_b};
        3'd2: alu_y <= {1'b0, alu_a & alu_b};
        3'd3: alu_y <= {1'b0, alu_a | alu_b};
        3'd4: alu_y <= {1'b0, alu_a ^ alu_b};
        3'd5: alu_y <= {1'b0, ~alu_a};
        3'd6: alu_y <= {alu_a, 1'b0};
        default: alu_y <= {2'b00, alu_a[W-1:1]};
      endcase
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    r0_valid  = 1'b0;
    r1_valid  = 1'b0;
    res_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int  ng, nr, idx;
  logic seen;
  int  gq[$];
  int  idq[$];
  int  yq[$];
  int  bp_exp [5] = '{100, 102, 104, 106, 108};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; res_ready = 1'b0;
    r0_valid = 1'b1; r0_a = 16'd49; r0_b = 16'd13; r0_sel = 3'b011;
    r1_valid = 1'b0; r1_a = '0; r1_b = '0; r1_sel = '0;

    // Reset state with a requester already valid.
    tick(); tick(); #1;
    chk("rst_r0_ready",  32'(r0_ready),  0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_busy",      32'(busy),      0);
    chk("rst_alu_a",     32'(alu_a),     0);
    chk("rst_res_y",     32'(res_y),     0);
    rst_n = 1'b1; #1;
    chk("rel_r0_ready", 32'(r0_ready), 1);

    // Single op: 49 | 13 = 61, result two cycles after the handshake.
    tick();
    r0_valid = 1'b0; #1;
    chk("op_alu_a",    32'(alu_a),   49);
    chk("op_alu_sel",  32'(alu_sel), 3);
    chk("op_busy",     32'(busy),    1);
    chk("op_valid_k0", 32'(res_valid), 0);
    tick();
    chk("op_valid_k1", 32'(res_valid), 0);
    tick();
    chk("op_valid_k2", 32'(res_valid), 1);
    chk("op_id",       32'(res_id),    0);
    chk("op_y",        32'(res_y),     61);
    res_ready = 1'b1;
    tick();
    chk("op_popped", 32'(res_valid), 0);
    chk("op_idle",   32'(busy),      0);

`ifndef ALU_SCHED_STRICT_PRIO_EN
    // Tie: 50+14=64 from r0, 13-7=6 from r1, grants alternate starting at r0.
    do_reset();
    r0_a = 16'd50; r0_b = 16'd14; r0_sel = 3'b000;
    r1_a = 16'd13; r1_b = 16'd7;  r1_sel = 3'b001;
    res_ready = 1'b1;
    ng = 0; nr = 0;
    gq.delete(); idq.delete(); yq.delete();
    for (int cyc = 0; cyc < 60 && (ng < 4 || nr < 4); cyc++) begin
      r0_valid = (ng < 4);
      r1_valid = (ng < 4);
      #1;
      chk("tie_onehot", 32'(r0_ready & r1_ready), 0);
      if (r0_ready) begin gq.push_back(0); ng++; end
      else if (r1_ready) begin gq.push_back(1); ng++; end
      if (res_valid) begin idq.push_back(int'(res_id)); yq.push_back(int'(res_y)); nr++; end
      tick();
    end
    chk("tie_grants",  32'(ng), 4);
    chk("tie_results", 32'(nr), 4);
    for (int i = 0; i < 4 && i < gq.size(); i++)  chk("tie_grant_order", 32'(gq[i]),  32'(i % 2));
    for (int i = 0; i < 4 && i < idq.size(); i++) chk("tie_res_id",      32'(idq[i]), 32'(i % 2));
    for (int i = 0; i < 4 && i < yq.size(); i++)  chk("tie_res_y",       32'(yq[i]),  (i % 2) ? 32'd6 : 32'd64);
`endif

    // Backpressure: five adds on r1 (100+i)+i, only two accepted while stalled.
    do_reset();
    r0_valid = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      r1_valid = (idx < 5);
      r1_a = 16'(100 + idx); r1_b = 16'(idx); r1_sel = 3'b000;
      #1;
      if (r1_ready) idx++;
      tick();
    end
    r1_a = 16'(100 + idx); r1_b = 16'(idx); #1;
    chk("bp_accepted",  32'(idx),       2);
    chk("bp_r1_ready",  32'(r1_ready),  0);
    chk("bp_res_valid", 32'(res_valid), 1);
    chk("bp_busy",      32'(busy),      1);
    res_ready = 1'b1;
    nr = 0;
    idq.delete(); yq.delete();
    for (int cyc = 0; cyc < 60 && nr < 5; cyc++) begin
      r1_valid = (idx < 5);
      r1_a = 16'(100 + idx); r1_b = 16'(idx);
      #1;
      if (r1_ready) idx++;
      if (res_valid) begin idq.push_back(int'(res_id)); yq.push_back(int'(res_y)); nr++; end
      tick();
    end
    chk("bp_pops", 32'(nr), 5);
    for (int i = 0; i < 5 && i < idq.size(); i++) chk("bp_res_id", 32'(idq[i]), 1);
    for (int i = 0; i < 5 && i < yq.size(); i++)  chk("bp_res_y",  32'(yq[i]),  32'(bp_exp[i]));
    #1;
    chk("bp_busy_end", 32'(busy), 0);

    // Mid-flight reset: 30 & 111 must never come out.
    do_reset();
    res_ready = 1'b1;
    r1_valid = 1'b0;
    r0_valid = 1'b1; r0_a = 16'd30; r0_b = 16'd111; r0_sel = 3'b010;
    #1;
    chk("mf_ready", 32'(r0_ready), 1);
    tick();
    r0_valid = 1'b0;
    tick();
    rst_n = 1'b0; #1;
    chk("mf_rst_alu_a",     32'(alu_a),     0);
    chk("mf_rst_alu_b",     32'(alu_b),     0);
    chk("mf_rst_alu_sel",   32'(alu_sel),   0);
    chk("mf_rst_busy",      32'(busy),      0);
    chk("mf_rst_res_valid", 32'(res_valid), 0);
    chk("mf_rst_res_id",    32'(res_id),    0);
    chk("mf_rst_res_y",     32'(res_y),     0);
    tick(); tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      #1;
      seen = seen | res_valid;
      tick();
    end
    chk("mf_never_valid", 32'(seen), 0);
    chk("mf_busy",        32'(busy), 0);

`ifdef ALU_SCHED_STRICT_PRIO_EN
    // Strict priority: r1 never granted; credit allows r0 on the first two cycles only.
    do_reset();
    res_ready = 1'b1;
    r0_valid = 1'b1; r1_valid = 1'b1;
    ng = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      #1;
      chk("strict_r1_ready", 32'(r1_ready), 0);
      if (r0_ready) ng++;
      tick();
    end
    chk("strict_r0_grants", 32'(ng), 2);
    r0_valid = 1'b0; r1_valid = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
